// File: rtl/stopwatch_pkg.sv
// ============================================================================
// Module : stopwatch_pkg
// Brief  : Shared digit geometry, digit indices and per-digit limits.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package stopwatch_pkg;

    localparam int NUM_DIGITS = 8;
    localparam int DIGIT_W    = 4;
    localparam int TIME_W     = NUM_DIGITS * DIGIT_W;

    localparam int IDX_C0 = 0;
    localparam int IDX_C1 = 1;
    localparam int IDX_S0 = 2;
    localparam int IDX_S1 = 3;
    localparam int IDX_M0 = 4;
    localparam int IDX_M1 = 5;
    localparam int IDX_H0 = 6;
    localparam int IDX_H1 = 7;

    // Tens-of-seconds and tens-of-minutes roll at 5, everything else at 9.
    function automatic int digit_max(input int idx);
        if (idx == IDX_S1 || idx == IDX_M1) begin
            return 5;
        end
        return 9;
    endfunction

    function automatic logic [DIGIT_W-1:0] get_digit(input logic [TIME_W-1:0] t, input int idx);
        return t[idx*DIGIT_W +: DIGIT_W];
    endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_digit.sv
// ============================================================================
// Module : bcd_digit
// Brief  : One BCD digit with up/down step, carry/borrow chain and load.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module bcd_digit
    import stopwatch_pkg::*;
#(
    parameter int MAX = 9
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               ld,
    input  logic [DIGIT_W-1:0] ld_val,
    input  logic               down,
    input  logic               cin,
    output logic [DIGIT_W-1:0] q,
    output logic               cout
);

    localparam logic [DIGIT_W-1:0] C_MAX = DIGIT_W'(MAX);

    logic [DIGIT_W-1:0] val_q;
    logic [DIGIT_W-1:0] val_d;

    always_comb begin
        val_d = val_q;
        if (ld) begin
            val_d = ld_val;
        end else if (cin) begin
            if (down) begin
                val_d = (val_q == '0) ? C_MAX : val_q - 4'd1;
            end else begin
                val_d = (val_q == C_MAX) ? '0 : val_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            val_q <= '0;
        end else begin
            val_q <= val_d;
        end
    end

    assign q    = val_q;
    assign cout = cin & (down ? (val_q == '0) : (val_q == C_MAX));

endmodule

`default_nettype wire

// File: rtl/stopwatch_core.sv
// ============================================================================
// Module : stopwatch_core
// Brief  : BCD HH:MM:SS.CC up/down stopwatch with exact prescaler, lap and load.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module stopwatch_core
    import stopwatch_pkg::*;
#(
    parameter int CLK_HZ    = 50_000_000,
    parameter int TICK_HZ   = 100,
    parameter int HOURS_MAX = 23,
    parameter int WRAP      = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_stop,
    input  logic        lap,
    input  logic        load,
    input  logic        mode_down,
    input  logic [31:0] preset_bcd,
    output logic [31:0] time_bcd,
    output logic [31:0] lap_bcd,
    output logic        lap_valid,
    output logic        running,
    output logic        done,
    output logic        wrapped,
    output logic        load_err
);

    localparam int                 DIV      = CLK_HZ / TICK_HZ;
    localparam int                 CNT_W    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(DIV - 1);
    localparam bit                 CC_EN    = (TICK_HZ != 1);
    localparam logic [DIGIT_W-1:0] HMAX_H1  = DIGIT_W'(HOURS_MAX / 10);
    localparam logic [DIGIT_W-1:0] HMAX_H0  = DIGIT_W'(HOURS_MAX % 10);

    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               running_q, running_d;
    logic               dir_q, dir_d;
    logic [DIGIT_W-1:0] h1_q, h1_d, h0_q, h0_d;
    logic               done_q, done_d;
    logic               wrapped_q, wrapped_d;
    logic               load_err_q, load_err_d;
    logic [31:0]        lap_bcd_q, lap_bcd_d;
    logic               lap_valid_q, lap_valid_d;

    logic [5:0][DIGIT_W-1:0] w_dig;
    logic [5:0]              w_cin;
    logic [5:0]              w_cout;
    logic                    w_pre_ok;
    logic [7:0]              w_pre_hours;
    logic                    w_load_acc, w_load_rej;
    logic                    w_tick, w_sat, w_step;
    logic                    w_at_limit, w_at_one, w_hours_max;

    assign time_bcd = {h1_q, h0_q, w_dig};

    always_comb begin
        w_pre_ok    = 1'b1;
        w_pre_hours = ({4'd0, get_digit(preset_bcd, IDX_H1)} * 8'd10)
                    + {4'd0, get_digit(preset_bcd, IDX_H0)};
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (get_digit(preset_bcd, i) > 4'd9) begin
                w_pre_ok = 1'b0;
            end
        end
        if (get_digit(preset_bcd, IDX_S1) > 4'd5 || get_digit(preset_bcd, IDX_M1) > 4'd5) begin
            w_pre_ok = 1'b0;
        end
        if (w_pre_hours > 8'(HOURS_MAX)) begin
            w_pre_ok = 1'b0;
        end
        if (!CC_EN && preset_bcd[7:0] != 8'h00) begin
            w_pre_ok = 1'b0;
        end
    end

    assign w_load_acc  = load & w_pre_ok;
    assign w_load_rej  = load & ~w_pre_ok;
    assign w_hours_max = (h1_q == HMAX_H1) && (h0_q == HMAX_H0);

    // With whole-second resolution the centisecond digits are pinned at 0.
    assign w_at_limit = w_hours_max && (w_dig[5] == 4'd5) && (w_dig[4] == 4'd9)
                     && (w_dig[3] == 4'd5) && (w_dig[2] == 4'd9)
                     && (CC_EN ? (w_dig[1] == 4'd9 && w_dig[0] == 4'd9) : 1'b1);
    assign w_at_one = (h1_q == '0) && (h0_q == '0)
                   && (CC_EN ? (w_dig[5:1] == '0 && w_dig[0] == 4'd1)
                             : (w_dig[5:3] == '0 && w_dig[2] == 4'd1 && w_dig[1:0] == '0));

    // Load and start_stop both pre-empt the tick of the same cycle.
    assign w_tick = running_q && (cnt_q == CNT_LAST) && !load && !start_stop;
    assign w_sat  = w_tick && !dir_q && w_at_limit && (WRAP == 0);
    assign w_step = w_tick && !w_sat;

    always_comb begin
        w_cin[0] = w_step & CC_EN;
        w_cin[1] = w_cout[0];
        w_cin[2] = CC_EN ? w_cout[1] : w_step;
        w_cin[3] = w_cout[2];
        w_cin[4] = w_cout[3];
        w_cin[5] = w_cout[4];
    end

    for (genvar g = 0; g < 6; g++) begin : g_digit
        bcd_digit #(
            .MAX (digit_max(g))
        ) u_digit (
            .clk    (clk),
            .reset  (reset),
            .ld     (w_load_acc),
            .ld_val (preset_bcd[g*DIGIT_W +: DIGIT_W]),
            .down   (dir_q),
            .cin    (w_cin[g]),
            .q      (w_dig[g]),
            .cout   (w_cout[g])
        );
    end

    always_comb begin
        cnt_d       = cnt_q;
        running_d   = running_q;
        dir_d       = dir_q;
        h1_d        = h1_q;
        h0_d        = h0_q;
        done_d      = 1'b0;
        wrapped_d   = 1'b0;
        load_err_d  = w_load_rej;
        lap_valid_d = lap;
        lap_bcd_d   = lap ? time_bcd : lap_bcd_q;

        if (w_load_acc) begin
            cnt_d = '0;
        end else if (!load && running_q) begin
            cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
        end

        if (w_load_acc) begin
            running_d = 1'b0;
        end else if (start_stop && !load) begin
            if (running_q) begin
                running_d = 1'b0;
            end else if (!(mode_down && time_bcd == '0)) begin
                running_d = 1'b1;
                dir_d     = mode_down;
            end
        end else if (w_sat) begin
            running_d = 1'b0;
            done_d    = 1'b1;
        end else if (w_step && dir_q && w_at_one) begin
            running_d = 1'b0;
            done_d    = 1'b1;
        end else if (w_step && !dir_q && w_at_limit) begin
            wrapped_d = 1'b1;
        end

        // The hour pair shares one joint limit, so it is stepped as a unit.
        if (w_load_acc) begin
            h1_d = get_digit(preset_bcd, IDX_H1);
            h0_d = get_digit(preset_bcd, IDX_H0);
        end else if (w_cout[5]) begin
            if (dir_q) begin
                if (h0_q == '0) begin
                    h0_d = 4'd9;
                    h1_d = h1_q - 4'd1;
                end else begin
                    h0_d = h0_q - 4'd1;
                end
            end else if (w_hours_max) begin
                h1_d = '0;
                h0_d = '0;
            end else if (h0_q == 4'd9) begin
                h0_d = '0;
                h1_d = h1_q + 4'd1;
            end else begin
                h0_d = h0_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q       <= '0;
            running_q   <= 1'b0;
            dir_q       <= 1'b0;
            h1_q        <= '0;
            h0_q        <= '0;
            done_q      <= 1'b0;
            wrapped_q   <= 1'b0;
            load_err_q  <= 1'b0;
            lap_bcd_q   <= '0;
            lap_valid_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            running_q   <= running_d;
            dir_q       <= dir_d;
            h1_q        <= h1_d;
            h0_q        <= h0_d;
            done_q      <= done_d;
            wrapped_q   <= wrapped_d;
            load_err_q  <= load_err_d;
            lap_bcd_q   <= lap_bcd_d;
            lap_valid_q <= lap_valid_d;
        end
    end

    assign lap_bcd   = lap_bcd_q;
    assign lap_valid = lap_valid_q;
    assign running   = running_q;
    assign done      = done_q;
    assign wrapped   = wrapped_q;
    assign load_err  = load_err_q;

endmodule

`default_nettype wire

// File: tb/tb_stopwatch_core.sv
// ============================================================================
// Module : tb_stopwatch_core
// Brief  : Scoreboard bench for stopwatch_core, wrapping and saturating builds.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_stopwatch_core;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start_stop = 1'b0;
    logic        lap = 1'b0;
    logic        load = 1'b0;
    logic        mode_down = 1'b0;
    logic [31:0] preset_bcd = '0;

    logic [31:0] time_bcd, lap_bcd;
    logic        lap_valid, running, done, wrapped, load_err;
    logic [31:0] s_time_bcd, s_lap_bcd;
    logic        s_lap_valid, s_running, s_done, s_wrapped, s_load_err;

    int nchk = 0;
    int nerr = 0;
    logic [31:0] exp_q[$];
    logic [31:0] lap_q[$];

    always #5 clk = ~clk;

    stopwatch_core #(.CLK_HZ(1000), .TICK_HZ(100), .HOURS_MAX(23), .WRAP(1)) dut (
        .clk(clk), .reset(reset), .start_stop(start_stop), .lap(lap), .load(load),
        .mode_down(mode_down), .preset_bcd(preset_bcd), .time_bcd(time_bcd),
        .lap_bcd(lap_bcd), .lap_valid(lap_valid), .running(running), .done(done),
        .wrapped(wrapped), .load_err(load_err)
    );

    stopwatch_core #(.CLK_HZ(1000), .TICK_HZ(100), .HOURS_MAX(23), .WRAP(0)) dut_sat (
        .clk(clk), .reset(reset), .start_stop(start_stop), .lap(lap), .load(load),
        .mode_down(mode_down), .preset_bcd(preset_bcd), .time_bcd(s_time_bcd),
        .lap_bcd(s_lap_bcd), .lap_valid(s_lap_valid), .running(s_running), .done(s_done),
        .wrapped(s_wrapped), .load_err(s_load_err)
    );

    function automatic logic [31:0] cs_to_bcd(input int cs);
        int h, m, s, c;
        h = cs / 360000;
        m = (cs / 6000) % 60;
        s = (cs / 100) % 60;
        c = cs % 100;
        return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10),
                4'(s / 10), 4'(s % 10), 4'(c / 10), 4'(c % 10)};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic do_start();
        start_stop = 1'b1;
        step();
        start_stop = 1'b0;
    endtask

    task automatic do_load(input logic [31:0] v);
        preset_bcd = v;
        load = 1'b1;
        step();
        load = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        nchk++;
        if ({time_bcd, lap_bcd, lap_valid, running, done, wrapped, load_err} !== '0) begin
            nerr++;
            $display("FAIL reset_wrap_dut time=%h lap=%h flags=%b expected all zero", time_bcd, lap_bcd,
                     {lap_valid, running, done, wrapped, load_err});
        end
        nchk++;
        if ({s_time_bcd, s_lap_bcd, s_lap_valid, s_running, s_done, s_wrapped, s_load_err} !== '0) begin
            nerr++;
            $display("FAIL reset_sat_dut time=%h lap=%h flags=%b expected all zero", s_time_bcd, s_lap_bcd,
                     {s_lap_valid, s_running, s_done, s_wrapped, s_load_err});
        end
    endtask

    task automatic test_count_up();
        logic [31:0] prev, e;
        int since;
        do_reset();
        do_start();
        nchk++;
        if (running !== 1'b1) begin nerr++; $display("FAIL up_running got %b expected 1", running); end
        for (int k = 1; k <= 100; k++) exp_q.push_back(cs_to_bcd(k));
        prev  = time_bcd;
        since = 0;
        for (int i = 1; i <= 1000; i++) begin
            step();
            since++;
            if (time_bcd !== prev) begin
                nchk++;
                if (exp_q.size() == 0) begin
                    nerr++;
                    $display("FAIL up_scoreboard got %h expected nothing pending", time_bcd);
                end else begin
                    e = exp_q.pop_front();
                    if (time_bcd !== e) begin
                        nerr++;
                        $display("FAIL up_scoreboard got %h expected %h", time_bcd, e);
                    end
                end
                nchk++;
                if (since != 10) begin
                    nerr++;
                    $display("FAIL tick_period got %0d cycles expected 10", since);
                end
                since = 0;
                prev  = time_bcd;
            end
        end
        nchk++;
        if (time_bcd !== 32'h0000_0100) begin
            nerr++; $display("FAIL up_1s got %h expected 00000100", time_bcd);
        end
        nchk++;
        if (exp_q.size() != 0) begin
            nerr++; $display("FAIL up_pending got %0d ticks left expected 0", exp_q.size());
        end
        exp_q.delete();
        do_start();
        repeat (20) step();
        nchk++;
        if ({running, time_bcd} !== {1'b0, 32'h0000_0100}) begin
            nerr++; $display("FAIL stop_hold got run=%b time=%h expected run=0 time=00000100", running, time_bcd);
        end
    endtask

    task automatic test_wrap_saturate();
        do_reset();
        do_load(32'h2359_5999);
        nchk++;
        if ({time_bcd, s_time_bcd} !== {32'h2359_5999, 32'h2359_5999}) begin
            nerr++; $display("FAIL limit_load got %h/%h expected 23595999", time_bcd, s_time_bcd);
        end
        do_start();
        for (int i = 1; i <= 12; i++) begin
            step();
            nchk++;
            if ({wrapped, s_done, done, s_wrapped} !== {(i == 10), (i == 10), 1'b0, 1'b0}) begin
                nerr++;
                $display("FAIL limit_pulses cycle %0d got wrapped=%b sat_done=%b done=%b sat_wrapped=%b expected %b %b 0 0",
                         i, wrapped, s_done, done, s_wrapped, (i == 10), (i == 10));
            end
            if (i == 10) begin
                nchk++;
                if ({time_bcd, running} !== {32'h0, 1'b1}) begin
                    nerr++; $display("FAIL wrap_value got time=%h run=%b expected 00000000 run=1", time_bcd, running);
                end
                nchk++;
                if ({s_time_bcd, s_running} !== {32'h2359_5999, 1'b0}) begin
                    nerr++; $display("FAIL sat_value got time=%h run=%b expected 23595999 run=0", s_time_bcd, s_running);
                end
            end
        end
    endtask

    task automatic test_count_down();
        logic [31:0] prev, e;
        do_reset();
        mode_down = 1'b1;
        do_load(32'h0000_0005);
        do_start();
        nchk++;
        if (running !== 1'b1) begin nerr++; $display("FAIL down_running got %b expected 1", running); end
        for (int k = 4; k >= 0; k--) exp_q.push_back(cs_to_bcd(k));
        prev = time_bcd;
        for (int i = 1; i <= 55; i++) begin
            step();
            if (time_bcd !== prev) begin
                nchk++;
                e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
                if (time_bcd !== e) begin
                    nerr++; $display("FAIL down_scoreboard got %h expected %h", time_bcd, e);
                end
                prev = time_bcd;
            end
            nchk++;
            if (done !== (i == 50)) begin
                nerr++; $display("FAIL down_done cycle %0d got %b expected %b", i, done, (i == 50));
            end
            if (i == 50) begin
                nchk++;
                if ({time_bcd, running} !== {32'h0, 1'b0}) begin
                    nerr++; $display("FAIL down_zero got time=%h run=%b expected 00000000 run=0", time_bcd, running);
                end
            end
        end
        exp_q.delete();
        do_start();
        step();
        nchk++;
        if (running !== 1'b0) begin nerr++; $display("FAIL down_zero_start got run=%b expected 0", running); end
        mode_down = 1'b0;
    endtask

    task automatic check_lap_pop(input string name);
        logic [31:0] e;
        nchk++;
        if (lap_valid !== 1'b1) begin
            nerr++; $display("FAIL %s got lap_valid=%b expected 1", name, lap_valid);
            if (lap_q.size() != 0) void'(lap_q.pop_front());
        end else if (lap_q.size() == 0) begin
            nerr++; $display("FAIL %s got lap %h expected no capture pending", name, lap_bcd);
        end else begin
            e = lap_q.pop_front();
            if (lap_bcd !== e) begin
                nerr++; $display("FAIL %s got lap %h expected %h", name, lap_bcd, e);
            end
        end
    endtask

    task automatic test_lap();
        do_reset();
        do_load(32'h0000_1234);
        do_start();
        repeat (9) step();
        lap = 1'b1;
        lap_q.push_back(32'h0000_1234);
        step();
        lap = 1'b0;
        nchk++;
        if (time_bcd !== 32'h0000_1235) begin
            nerr++; $display("FAIL lap_tick_time got %h expected 00001235", time_bcd);
        end
        check_lap_pop("lap_same_tick");
        step();
        nchk++;
        if (lap_valid !== 1'b0) begin nerr++; $display("FAIL lap_valid_width got %b expected 0", lap_valid); end
        do_start();
        lap = 1'b1;
        lap_q.push_back(32'h0000_1235);
        step();
        check_lap_pop("lap_stopped_first");
        lap_q.push_back(32'h0000_1235);
        step();
        lap = 1'b0;
        check_lap_pop("lap_back_to_back");
        step();
        nchk++;
        if (lap_valid !== 1'b0) begin nerr++; $display("FAIL lap_valid_end got %b expected 0", lap_valid); end
    endtask

    task automatic test_load();
        logic [31:0] bad [4];
        bad = '{32'h0061_0000, 32'h2400_0000, 32'h0000_0A00, 32'h0000_7000};
        do_reset();
        do_load(32'h0000_1234);
        nchk++;
        if ({time_bcd, load_err} !== {32'h0000_1234, 1'b0}) begin
            nerr++; $display("FAIL load_ok got time=%h err=%b expected 00001234 err=0", time_bcd, load_err);
        end
        for (int i = 0; i < 4; i++) begin
            do_load(bad[i]);
            nchk++;
            if ({time_bcd, load_err} !== {32'h0000_1234, 1'b1}) begin
                nerr++; $display("FAIL load_reject %h got time=%h err=%b expected 00001234 err=1", bad[i], time_bcd, load_err);
            end
            step();
            nchk++;
            if (load_err !== 1'b0) begin nerr++; $display("FAIL load_err_width got %b expected 0", load_err); end
        end
        do_start();
        do_load(32'h0061_0000);
        nchk++;
        if ({running, load_err} !== 2'b11) begin
            nerr++; $display("FAIL load_reject_running got run=%b err=%b expected 1 1", running, load_err);
        end
        preset_bcd = 32'h0000_0500;
        load = 1'b1;
        start_stop = 1'b1;
        step();
        load = 1'b0;
        start_stop = 1'b0;
        repeat (20) step();
        nchk++;
        if ({time_bcd, running, load_err} !== {32'h0000_0500, 1'b0, 1'b0}) begin
            nerr++; $display("FAIL load_with_start got time=%h run=%b err=%b expected 00000500 0 0", time_bcd, running, load_err);
        end
    endtask

    task automatic test_resume_and_reset();
        do_reset();
        do_start();
        repeat (7) step();
        start_stop = 1'b1;
        step();
        start_stop = 1'b0;
        repeat (5) step();
        nchk++;
        if ({time_bcd, running} !== {32'h0, 1'b0}) begin
            nerr++; $display("FAIL stop_at_7 got time=%h run=%b expected 00000000 0", time_bcd, running);
        end
        do_start();
        step();
        nchk++;
        if (time_bcd !== 32'h0) begin nerr++; $display("FAIL resume_early got %h expected 00000000", time_bcd); end
        step();
        nchk++;
        if (time_bcd !== 32'h0000_0001) begin nerr++; $display("FAIL resume_tick got %h expected 00000001", time_bcd); end
        repeat (3) step();
        lap = 1'b1;
        reset = 1'b1;
        step();
        lap = 1'b0;
        reset = 1'b0;
        nchk++;
        if ({time_bcd, lap_bcd, lap_valid, running, done, wrapped, load_err} !== '0) begin
            nerr++; $display("FAIL reset_mid got time=%h lap=%h flags=%b expected all zero", time_bcd, lap_bcd,
                             {lap_valid, running, done, wrapped, load_err});
        end
        step();
        nchk++;
        if ({time_bcd, lap_valid, running} !== '0) begin
            nerr++; $display("FAIL reset_no_pending got time=%h lap_valid=%b run=%b expected zero", time_bcd, lap_valid, running);
        end
    endtask

    initial begin
        test_reset();
        test_count_up();
        test_wrap_saturate();
        test_count_down();
        test_lap();
        test_load();
        test_resume_and_reset();
        $display("CHECKS %0d ERRORS %0d", nchk, nerr);
        $finish;
    end

endmodule

`default_nettype wire
